// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary encoder front end.
package rotary_pkg;

  typedef enum logic [2:0] {
    StRest,
    StCw1,
    StCw2,
    StCw3,
    StCcw1,
    StCcw2,
    StCcw3,
    StResync
  } quad_state_t;

  typedef logic [1:0] step_sel_t;

  localparam int unsigned ACCEL_MULT = 4;

  localparam int unsigned STEP0_DEF = 1;
  localparam int unsigned STEP1_DEF = 10;
  localparam int unsigned STEP2_DEF = 100;

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchroniser followed by a stability filter; the output follows the
// pin only after DEB_CYCLES consecutive identical synchronised samples.
module rot_debounce #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned RW = $clog2(DEB_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;
  logic          lvl_q, lvl_d;

  always_comb begin
    prev_d = prev_q;
    run_d  = run_q;
    lvl_d  = lvl_q;
    if (sync2_q != prev_q) begin
      prev_d = sync2_q;
      run_d  = RW'(1);
    end else if (run_q < RUN_MAX) begin
      run_d = run_q + RW'(1);
    end
    if (run_d == RUN_MAX) lvl_d = prev_d;
  end

  // Run counter starts saturated so the reset level is already "stable".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      prev_q  <= RST_VAL;
      run_q   <= RUN_MAX;
      lvl_q   <= RST_VAL;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      run_q   <= run_d;
      lvl_q   <= lvl_d;
    end
  end

  assign dout = lvl_q;

endmodule

// File: rtl/rotary_value_ctrl.sv
// Rotary encoder front end: debounce, quadrature detent decode, saturating setpoint
// with step table and mode floor, periodic publish. Define ROT_ACCEL_EN for 4x acceleration.
module rotary_value_ctrl
  import rotary_pkg::*;
#(
  parameter int unsigned VAL_W      = 11,
  parameter int unsigned VAL_MAX    = 1800,
  parameter int unsigned ALT_MODE   = 4,
  parameter int unsigned ALT_MIN    = 800,
  parameter int unsigned STEP0      = STEP0_DEF,
  parameter int unsigned STEP1      = STEP1_DEF,
  parameter int unsigned STEP2      = STEP2_DEF,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned UPDATE_DIV = 2400,
  parameter int unsigned ACCEL_WIN  = 50000
) (
  input  logic             Fg_CLK,
  input  logic             RESETn,
  input  logic             Rot_A,
  input  logic             Rot_B,
  input  logic             Rot_C,
  input  logic [2:0]       Mode,
  output logic [VAL_W-1:0] Value,
  output logic             ValChng,
  output logic [1:0]       StepSel
);

  localparam int unsigned W  = VAL_W + 1;
  localparam int unsigned DW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [W-1:0]  VAL_MAX_W = W'(VAL_MAX);
  localparam logic [W-1:0]  ALT_MIN_W = W'(ALT_MIN);
  localparam logic [DW-1:0] DIV_LAST  = DW'(UPDATE_DIV - 1);

  logic a_deb, b_deb, c_deb;

  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_a (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_A), .dout(a_deb));
  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_b (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_B), .dout(b_deb));
  rot_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_c (
    .clk(Fg_CLK), .rst_n(RESETn), .din(Rot_C), .dout(c_deb));

  quad_state_t      state_q, state_d;
  logic             cw_evt, ccw_evt;
  logic [1:0]       ab;
  logic [VAL_W-1:0] count_q, count_d;
  step_sel_t        step_sel_q, step_sel_d;
  logic             c_prev_q;
  logic [DW-1:0]    div_q;
  logic             tick;
  logic [VAL_W-1:0] value_q;
  logic             val_chng_q;
  logic             alt;
  logic [W-1:0]     step_base, step_w, floor_w, count_ext, sum_w;
  logic             accel;

  assign ab = {a_deb, b_deb};

  // Each state remembers the AB code it was entered on; a two-bit jump is a loss of sync.
  always_comb begin
    state_d = state_q;
    cw_evt  = 1'b0;
    ccw_evt = 1'b0;
    unique case (state_q)
      StRest: case (ab)
        2'b10: state_d = StCw1;
        2'b01: state_d = StCcw1;
        2'b00: state_d = StResync;
        default: ;
      endcase
      StCw1: case (ab)
        2'b00: state_d = StCw2;
        2'b11: state_d = StRest;
        2'b01: state_d = StResync;
        default: ;
      endcase
      StCw2: case (ab)
        2'b01: state_d = StCw3;
        2'b10: state_d = StCw1;
        2'b11: state_d = StResync;
        default: ;
      endcase
      StCw3: case (ab)
        2'b11: begin state_d = StRest; cw_evt = 1'b1; end
        2'b00: state_d = StCw2;
        2'b10: state_d = StResync;
        default: ;
      endcase
      StCcw1: case (ab)
        2'b00: state_d = StCcw2;
        2'b11: state_d = StRest;
        2'b10: state_d = StResync;
        default: ;
      endcase
      StCcw2: case (ab)
        2'b10: state_d = StCcw3;
        2'b01: state_d = StCcw1;
        2'b11: state_d = StResync;
        default: ;
      endcase
      StCcw3: case (ab)
        2'b11: begin state_d = StRest; ccw_evt = 1'b1; end
        2'b00: state_d = StCcw2;
        2'b01: state_d = StResync;
        default: ;
      endcase
      StResync: if (ab == 2'b11) state_d = StRest;
      default: state_d = StRest;
    endcase
  end

`ifdef ROT_ACCEL_EN
  localparam int unsigned TW = $clog2(ACCEL_WIN + 1);
  localparam logic [TW-1:0] ACCEL_WIN_T = TW'(ACCEL_WIN);

  logic [TW-1:0] timer_q;
  logic          last_cw_q;

  assign accel = (timer_q < ACCEL_WIN_T) &&
                 ((cw_evt && last_cw_q) || (ccw_evt && !last_cw_q));

  // Timer starts saturated so the first detent after reset is never accelerated.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      timer_q   <= ACCEL_WIN_T;
      last_cw_q <= 1'b0;
    end else if (cw_evt || ccw_evt) begin
      timer_q   <= '0;
      last_cw_q <= cw_evt;
    end else if (timer_q < ACCEL_WIN_T) begin
      timer_q <= timer_q + TW'(1);
    end
  end
`else
  assign accel = 1'b0;
`endif

  always_comb begin
    case (step_sel_q)
      2'd0:    step_base = W'(STEP0);
      2'd1:    step_base = W'(STEP1);
      default: step_base = W'(STEP2);
    endcase
    step_w    = accel ? step_base * W'(ACCEL_MULT) : step_base;
    alt       = ({29'd0, Mode} == ALT_MODE);
    floor_w   = alt ? ALT_MIN_W : '0;
    count_ext = {1'b0, count_q};
    sum_w     = count_ext + step_w;
    count_d   = count_q;
    if (alt && count_ext < ALT_MIN_W) begin
      count_d = ALT_MIN_W[VAL_W-1:0];
    end else if (cw_evt) begin
      count_d = (sum_w > VAL_MAX_W) ? VAL_MAX_W[VAL_W-1:0] : sum_w[VAL_W-1:0];
    end else if (ccw_evt) begin
      count_d = (count_ext >= step_w + floor_w) ? VAL_W'(count_ext - step_w)
                                                : floor_w[VAL_W-1:0];
    end
  end

  always_comb begin
    step_sel_d = step_sel_q;
    if (c_deb && !c_prev_q) step_sel_d = (step_sel_q == 2'd2) ? 2'd0 : step_sel_q + 2'd1;
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= StRest;
      count_q    <= '0;
      step_sel_q <= 2'd0;
      c_prev_q   <= 1'b0;
      div_q      <= '0;
      value_q    <= '0;
      val_chng_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      step_sel_q <= step_sel_d;
      c_prev_q   <= c_deb;
      div_q      <= tick ? '0 : div_q + DW'(1);
      val_chng_q <= tick && (count_q != value_q);
      if (tick) value_q <= count_q;
    end
  end

  assign Value   = value_q;
  assign ValChng = val_chng_q;
  assign StepSel = step_sel_q;

endmodule
